phase_seq: RTL and testbench
============================

Name: phase_seq

Overview:
Multicycle control sequencer for the 5-phase processor datapath (fetch, register read, execute, memory, writeback).
- Replaces the free-running ring counter plus ad-hoc enables.
- Generates a one-hot phase and all per-phase strobes: IR load, PC increment/branch, memory request/write, register-file write, writeback mux select.
- Stalls on a memory request/acknowledge handshake, skips the memory phase for non-memory instructions, evaluates branch conditions from latched ALU flags, and provides halt and timeout-error states.

Parameters:
- TIMEOUT, 16: max cycles waiting for mem_ack in F or M before entering ERR; 0 disables the timeout.
- TW, 5: width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- is_load  in  1  decoded instruction is a load
- is_store  in  1  decoded instruction is a store
- is_branch  in  1  decoded instruction is a branch
- is_halt  in  1  decoded instruction is halt
- rf_wr  in  1  instruction writes a register (ALU op or load)
- flag_wr  in  1  instruction updates flags (ADD/SUB/CMP/NEG)
- cond  in  3  branch condition code
- zf, sf, cf, of  in  1 each  ALU flags, valid during X
- mem_ack  in  1  memory completed the current request
- phase  out  5  one-hot: bit0 F, bit1 R, bit2 X, bit3 M, bit4 W; 0 in IDLE/HALT/ERR
- mem_req  out  1  memory request (F: instruction fetch, M: data access)
- mem_sel  out  1  address source: 0 = pc, 1 = dr
- wren_mem  out  1  memory write enable
- ir_we  out  1  load IR from q_mem
- pc_inc  out  1  pc <= pc + 4
- ct_taken  out  1  pc <= dr
- rf_we  out  1  register-file write enable
- wd_sel  out  1  writeback data: 0 = dr, 1 = q_mem
- halted  out  1  sticky halt indicator
- err  out  1  sticky memory-timeout indicator

Behaviour:
- States: IDLE, F, R, X, M, W, HALT, ERR. Outputs are Moore, decoded from state, except the strobes gated by mem_ack or by decode inputs as noted below.
- Reset:
  - State goes to IDLE; flag register {z,s,c,o} = 0; timeout counter = 0.
  - All outputs are 0 while in IDLE.
  - IDLE -> F unconditionally on the next clock.
- Reset asserted mid-operation aborts any pending memory request immediately: mem_req and wren_mem drop asynchronously.
- F:
  - Outputs: mem_req = 1, mem_sel = 0.
  - On mem_ack: ir_we = 1 in the same cycle, then -> R.
  - Otherwise stay in F.
- R: one cycle, then -> X.
- X:
  - If flag_wr, latch {zf,sf,cf,of} at the end of the cycle.
  - Next state: is_halt -> HALT; (is_load | is_store) -> M; else -> W.
- M:
  - Outputs: mem_req = 1, mem_sel = 1, wren_mem = is_store. Held constant until ack.
  - On mem_ack -> W.
  - For a load, the q_mem captured on the ack cycle is written in W; the datapath holds q_mem.
- W (one cycle, then -> F):
  - rf_we = rf_wr; wd_sel = is_load.
  - If is_branch and the condition is true: ct_taken = 1, pc_inc = 0. Otherwise pc_inc = 1.
  - ct_taken and pc_inc are never both 1.
- Branch condition codes (evaluated on latched flags; flags written in the same instruction's X are visible in its W):
  - 000 always
  - 001 z
  - 010 !z
  - 011 s^o (signed lt)
  - 100 !(s^o) (signed ge)
  - 101 c (unsigned lt)
  - 110 !c
  - 111 never
- Timeout:
  - The counter clears on entry to F or M and increments each cycle without mem_ack.
  - When the counter reaches TIMEOUT without ack -> ERR; err = 1.
  - An ack arriving in the same cycle the count reaches TIMEOUT wins: normal transition.
- HALT and ERR are absorbing until reset. halted = 1 in HALT. All strobes and phase are 0 in both states.
- A mem_ack outside F or M is ignored.
- Decode inputs are sampled only in X and W; the IR is stable from R onward.

Optional Feature:
Macro PHASE_SEQ_PERF_EN.
- When defined, adds outputs:
  - cyc_cnt[31:0]: cycles since reset, excluding IDLE; freezes in HALT/ERR.
  - ret_cnt[31:0]: +1 per W cycle.
  - stall_cnt[31:0]: +1 per F/M cycle without mem_ack.
- All counters reset to 0 and wrap modulo 2^32.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package phase_seq_pkg holds:
  - state encodings
  - phase bit indices F=0, R=1, X=2, M=3, W=4
  - branch condition codes COND_AL..COND_NV
- Sub-module br_cond: combinational condition evaluator, inputs cond and {z,s,c,o}, output 1-bit taken. Reused by a later pipelined core.

Test Plan:
- ALU op (rf_wr=1, no memory), mem_ack tied 1 → phase sequence after reset: 0, 00001, 00010, 00100, 10000, 00001. rf_we=1 and pc_inc=1 only in W; 4 cycles per instruction.
- Load with mem_ack delayed 3 cycles in both F and M → F held 4 cycles; ir_we single pulse on the ack cycle; M held 4 cycles with wren_mem=0; W has rf_we=1, wd_sel=1.
- Store → M has wren_mem=1 and mem_sel=1 until ack; W has rf_we=0 and pc_inc=1.
- CMP sets z=1 (flag_wr), then branch cond=001 → ct_taken=1, pc_inc=0 in W. Same test with cond=010 → pc_inc=1. cond=111 never taken.
- mem_ack withheld with TIMEOUT=16 → ERR entered after 16 F cycles; err=1 and phase=0 until n_rst. Ack exactly on the 16th cycle → normal progression.
- is_halt in X → HALT, halted=1, no further mem_req. Assert n_rst low mid-M with mem_req=1 → mem_req drops immediately; IDLE then F after release.

Source files
------------

// File: rtl/phase_seq_pkg.sv
// Shared definitions for the multicycle phase sequencer.
// Holds state encodings, phase bit indices and branch condition codes.
package phase_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_F    = 3'd1,
    ST_R    = 3'd2,
    ST_X    = 3'd3,
    ST_M    = 3'd4,
    ST_W    = 3'd5,
    ST_HALT = 3'd6,
    ST_ERR  = 3'd7
  } state_t;

  localparam int PH_F = 0;
  localparam int PH_R = 1;
  localparam int PH_X = 2;
  localparam int PH_M = 3;
  localparam int PH_W = 4;
  localparam int NPH  = 5;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_CS = 3'b101;
  localparam logic [2:0] COND_CC = 3'b110;
  localparam logic [2:0] COND_NV = 3'b111;

  typedef struct packed {
    logic z;
    logic s;
    logic c;
    logic o;
  } flags_t;

  // One-hot phase vector for a state; non-executing states give all zeros.
  function automatic logic [NPH-1:0] phase_of(state_t st);
    logic [NPH-1:0] ph;
    ph = '0;
    case (st)
      ST_F:    ph[PH_F] = 1'b1;
      ST_R:    ph[PH_R] = 1'b1;
      ST_X:    ph[PH_X] = 1'b1;
      ST_M:    ph[PH_M] = 1'b1;
      ST_W:    ph[PH_W] = 1'b1;
      default: ph = '0;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/br_cond.sv
// Combinational branch condition evaluator over latched {z,s,c,o} flags.
module br_cond
  import phase_seq_pkg::*;
(
  input  logic [2:0] cond,
  input  flags_t     flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = flags.z;
      COND_NE: taken = ~flags.z;
      COND_LT: taken = flags.s ^ flags.o;
      COND_GE: taken = ~(flags.s ^ flags.o);
      COND_CS: taken = flags.c;
      COND_CC: taken = ~flags.c;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/phase_seq.sv
// Multicycle control sequencer: F -> R -> X -> [M] -> W with memory handshake stalls.
// Optional performance counters are built when PHASE_SEQ_PERF_EN is defined.
module phase_seq
  import phase_seq_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
)(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       is_load,
  input  logic       is_store,
  input  logic       is_branch,
  input  logic       is_halt,
  input  logic       rf_wr,
  input  logic       flag_wr,
  input  logic [2:0] cond,
  input  logic       zf,
  input  logic       sf,
  input  logic       cf,
  input  logic       of,
  input  logic       mem_ack,
  output logic [4:0] phase,
  output logic       mem_req,
  output logic       mem_sel,
  output logic       wren_mem,
  output logic       ir_we,
  output logic       pc_inc,
  output logic       ct_taken,
  output logic       rf_we,
  output logic       wd_sel,
  output logic       halted,
`ifdef PHASE_SEQ_PERF_EN
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt,
  output logic [31:0] stall_cnt,
`endif
  output logic       err
);

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state_reg, state_next;
  flags_t        flags_reg, flags_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          mem_phase;
  logic          tmo_hit;
  logic          br_taken;
  logic          take_branch;

  assign mem_phase   = (state_reg == ST_F) || (state_reg == ST_M);
  assign tmo_hit     = (TIMEOUT != 0) && (tmo_reg == TMO_LAST);
  assign take_branch = is_branch & br_taken;

  br_cond u_br_cond (
    .cond  (cond),
    .flags (flags_reg),
    .taken (br_taken)
  );

  // Async reset drops state to IDLE at once, which kills mem_req/wren_mem immediately.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= ST_IDLE;
      flags_reg <= '0;
      tmo_reg   <= '0;
    end else begin
      state_reg <= state_next;
      flags_reg <= flags_next;
      tmo_reg   <= tmo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: state_next = ST_F;
      ST_F: begin
        if (mem_ack)      state_next = ST_R;
        else if (tmo_hit) state_next = ST_ERR;
      end
      ST_R: state_next = ST_X;
      ST_X: begin
        if (is_halt)                  state_next = ST_HALT;
        else if (is_load || is_store) state_next = ST_M;
        else                          state_next = ST_W;
      end
      ST_M: begin
        if (mem_ack)      state_next = ST_W;
        else if (tmo_hit) state_next = ST_ERR;
      end
      ST_W:    state_next = ST_F;
      ST_HALT: state_next = ST_HALT;
      ST_ERR:  state_next = ST_ERR;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    flags_next = flags_reg;
    if ((state_reg == ST_X) && flag_wr)
      flags_next = '{z: zf, s: sf, c: cf, o: of};
  end

  // Counter restarts whenever a memory-waiting phase is freshly entered.
  always_comb begin
    tmo_next = tmo_reg;
    if (((state_next == ST_F) || (state_next == ST_M)) && (state_next != state_reg))
      tmo_next = '0;
    else if (mem_phase && !mem_ack && (TIMEOUT != 0))
      tmo_next = tmo_reg + 1'b1;
  end

  always_comb begin
    phase    = phase_of(state_reg);
    mem_req  = 1'b0;
    mem_sel  = 1'b0;
    wren_mem = 1'b0;
    ir_we    = 1'b0;
    pc_inc   = 1'b0;
    ct_taken = 1'b0;
    rf_we    = 1'b0;
    wd_sel   = 1'b0;
    halted   = 1'b0;
    err      = 1'b0;
    case (state_reg)
      ST_F: begin
        mem_req = 1'b1;
        ir_we   = mem_ack;
      end
      ST_M: begin
        mem_req  = 1'b1;
        mem_sel  = 1'b1;
        wren_mem = is_store;
      end
      ST_W: begin
        rf_we    = rf_wr;
        wd_sel   = is_load;
        ct_taken = take_branch;
        pc_inc   = ~take_branch;
      end
      ST_HALT: halted = 1'b1;
      ST_ERR:  err    = 1'b1;
      default: ;
    endcase
  end

`ifdef PHASE_SEQ_PERF_EN
  logic [31:0] cyc_cnt_reg, ret_cnt_reg, stall_cnt_reg;
  logic        running;

  assign running = (state_reg != ST_IDLE) && (state_reg != ST_HALT) && (state_reg != ST_ERR);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cyc_cnt_reg   <= '0;
      ret_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (running)
        cyc_cnt_reg <= cyc_cnt_reg + 32'd1;
      if (state_reg == ST_W)
        ret_cnt_reg <= ret_cnt_reg + 32'd1;
      if (mem_phase && !mem_ack)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign cyc_cnt   = cyc_cnt_reg;
  assign ret_cnt   = ret_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_phase_seq.sv
// Scoreboard bench for phase_seq: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_phase_seq;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       is_load = 1'b0, is_store = 1'b0, is_branch = 1'b0, is_halt = 1'b0;
  logic       rf_wr = 1'b0, flag_wr = 1'b0;
  logic [2:0] cond = 3'b000;
  logic       zf = 1'b0, sf = 1'b0, cf = 1'b0, of = 1'b0;
  logic       mem_ack = 1'b0;
  logic [4:0] phase;
  logic       mem_req, mem_sel, wren_mem, ir_we, pc_inc, ct_taken, rf_we, wd_sel, halted, err;
`ifdef PHASE_SEQ_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt, stall_cnt;
`endif

  typedef struct packed {
    logic [4:0] phase;
    logic mem_req, mem_sel, wren_mem, ir_we, pc_inc, ct_taken, rf_we, wd_sel, halted, err;
  } out_t;

  out_t  act;
  out_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  assign act = {phase, mem_req, mem_sel, wren_mem, ir_we, pc_inc, ct_taken, rf_we, wd_sel, halted, err};

  always #5 clk = ~clk;

  phase_seq #(.TIMEOUT(16), .TW(5)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_halt   (is_halt),
    .rf_wr     (rf_wr),
    .flag_wr   (flag_wr),
    .cond      (cond),
    .zf        (zf),
    .sf        (sf),
    .cf        (cf),
    .of        (of),
    .mem_ack   (mem_ack),
    .phase     (phase),
    .mem_req   (mem_req),
    .mem_sel   (mem_sel),
    .wren_mem  (wren_mem),
    .ir_we     (ir_we),
    .pc_inc    (pc_inc),
    .ct_taken  (ct_taken),
    .rf_we     (rf_we),
    .wd_sel    (wd_sel),
    .halted    (halted),
`ifdef PHASE_SEQ_PERF_EN
    .cyc_cnt   (cyc_cnt),
    .ret_cnt   (ret_cnt),
    .stall_cnt (stall_cnt),
`endif
    .err       (err)
  );

  // Expected-output constructors; the test supplies the hand-derived strobe values.
  function automatic out_t e_idle();
    out_t e;
    e = '0;
    return e;
  endfunction

  function automatic out_t e_f(input logic ack);
    out_t e;
    e = '0;
    e.phase = 5'b00001;
    e.mem_req = 1'b1;
    e.ir_we = ack;
    return e;
  endfunction

  function automatic out_t e_r();
    out_t e;
    e = '0;
    e.phase = 5'b00010;
    return e;
  endfunction

  function automatic out_t e_x();
    out_t e;
    e = '0;
    e.phase = 5'b00100;
    return e;
  endfunction

  function automatic out_t e_m(input logic wr);
    out_t e;
    e = '0;
    e.phase = 5'b01000;
    e.mem_req = 1'b1;
    e.mem_sel = 1'b1;
    e.wren_mem = wr;
    return e;
  endfunction

  function automatic out_t e_w(input logic pci, input logic ctt, input logic rfw, input logic wds);
    out_t e;
    e = '0;
    e.phase = 5'b10000;
    e.pc_inc = pci;
    e.ct_taken = ctt;
    e.rf_we = rfw;
    e.wd_sel = wds;
    return e;
  endfunction

  function automatic out_t e_halt();
    out_t e;
    e = '0;
    e.halted = 1'b1;
    return e;
  endfunction

  function automatic out_t e_err();
    out_t e;
    e = '0;
    e.err = 1'b1;
    return e;
  endfunction

  task automatic step(input logic ack, input out_t e, input string nm);
    mem_ack = ack;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic ld, input logic st, input logic br, input logic hl,
                         input logic rw, input logic fw, input logic [2:0] cc);
    is_load = ld; is_store = st; is_branch = br; is_halt = hl;
    rf_wr = rw; flag_wr = fw; cond = cc;
  endtask

  // Plain instruction with immediate acks and no memory phase.
  task automatic run_short(input string nm, input out_t w_exp);
    step(1'b1, e_f(1'b1), {nm, "_f"});
    step(1'b1, e_r(), {nm, "_r"});
    step(1'b1, e_x(), {nm, "_x"});
    step(1'b1, w_exp, {nm, "_w"});
  endtask

  always @(negedge clk) begin : monitor
    out_t  e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got phase=%b strobes=%b, expected phase=%b strobes=%b",
                 nm, act.phase, act[9:0], e.phase, e[9:0]);
      end else begin
        $display("ok   %s: phase=%b strobes=%b", nm, act.phase, act[9:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    step(1'b0, e_idle(), "rst_hold0");
    step(1'b1, e_idle(), "rst_hold1");
    n_rst = 1'b1;
    step(1'b1, e_idle(), "idle");

    // ALU op, two back-to-back instructions
    set_dec(0, 0, 0, 0, 1, 0, 3'b000);
    run_short("alu1", e_w(1, 0, 1, 0));
    run_short("alu2", e_w(1, 0, 1, 0));

    // Load with three-cycle ack delay in F and M
    set_dec(1, 0, 0, 0, 1, 0, 3'b000);
    for (int i = 0; i < 3; i++) step(1'b0, e_f(1'b0), "ld_f_wait");
    step(1'b1, e_f(1'b1), "ld_f_ack");
    step(1'b1, e_r(), "ld_r");
    step(1'b1, e_x(), "ld_x");
    for (int i = 0; i < 3; i++) step(1'b0, e_m(1'b0), "ld_m_wait");
    step(1'b1, e_m(1'b0), "ld_m_ack");
    step(1'b0, e_w(1, 0, 1, 1), "ld_w");

    // Store
    set_dec(0, 1, 0, 0, 0, 0, 3'b000);
    step(1'b1, e_f(1'b1), "st_f");
    step(1'b1, e_r(), "st_r");
    step(1'b1, e_x(), "st_x");
    step(1'b0, e_m(1'b1), "st_m_wait");
    step(1'b1, e_m(1'b1), "st_m_ack");
    step(1'b0, e_w(1, 0, 0, 0), "st_w");

    // CMP sets z, then branches read the latched flags
    set_dec(0, 0, 0, 0, 0, 1, 3'b000);
    zf = 1'b1;
    run_short("cmp", e_w(1, 0, 0, 0));
    zf = 1'b0;
    set_dec(0, 0, 1, 0, 0, 0, 3'b001);
    run_short("beq", e_w(0, 1, 0, 0));
    set_dec(0, 0, 1, 0, 0, 0, 3'b010);
    run_short("bne", e_w(1, 0, 0, 0));
    set_dec(0, 0, 1, 0, 0, 0, 3'b111);
    run_short("bnv", e_w(1, 0, 0, 0));
    set_dec(0, 0, 1, 0, 0, 0, 3'b000);
    run_short("bal", e_w(0, 1, 0, 0));

    // Flags written in X are visible in the same instruction's W
    sf = 1'b1;
    set_dec(0, 0, 1, 0, 0, 1, 3'b011);
    run_short("blt_self", e_w(0, 1, 0, 0));
    sf = 1'b0;
    set_dec(0, 0, 1, 0, 0, 0, 3'b010);
    run_short("bne_z0", e_w(0, 1, 0, 0));
    set_dec(0, 0, 1, 0, 0, 0, 3'b100);
    run_short("bge_lt", e_w(1, 0, 0, 0));
    set_dec(0, 0, 1, 0, 0, 0, 3'b110);
    run_short("bcc", e_w(0, 1, 0, 0));

    // Fetch timeout: 16 cycles without ack, then absorbing ERR
    set_dec(0, 0, 0, 0, 1, 0, 3'b000);
    for (int i = 0; i < 16; i++) step(1'b0, e_f(1'b0), "tmo_f_wait");
    for (int i = 0; i < 3; i++) step(1'b1, e_err(), "tmo_err");

    // Ack on the 16th cycle wins over the timeout
    n_rst = 1'b0;
    step(1'b0, e_idle(), "err_rst");
    n_rst = 1'b1;
    step(1'b0, e_idle(), "err_rst_idle");
    for (int i = 0; i < 15; i++) step(1'b0, e_f(1'b0), "edge_f_wait");
    step(1'b1, e_f(1'b1), "edge_f_ack16");
    step(1'b1, e_r(), "edge_r");
    step(1'b1, e_x(), "edge_x");
    step(1'b1, e_w(1, 0, 1, 0), "edge_w");

    // Halt is absorbing and ignores acks
    set_dec(0, 0, 0, 1, 0, 0, 3'b000);
    step(1'b1, e_f(1'b1), "hlt_f");
    step(1'b1, e_r(), "hlt_r");
    step(1'b1, e_x(), "hlt_x");
    for (int i = 0; i < 3; i++) step(1'b1, e_halt(), "hlt_hold");

    // Reset mid-M during a store: mem_req and wren_mem drop before the next edge
    n_rst = 1'b0;
    step(1'b0, e_idle(), "hlt_rst");
    n_rst = 1'b1;
    set_dec(0, 1, 0, 0, 0, 0, 3'b000);
    step(1'b0, e_idle(), "mr_idle");
    step(1'b1, e_f(1'b1), "mr_f");
    step(1'b1, e_r(), "mr_r");
    step(1'b1, e_x(), "mr_x");
    step(1'b0, e_m(1'b1), "mr_m");
    n_rst = 1'b0;
    step(1'b0, e_idle(), "mr_async_drop");
    n_rst = 1'b1;
    step(1'b0, e_idle(), "mr_idle2");
    step(1'b1, e_f(1'b1), "mr_f2");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
